// File: rtl/rice_run_serializer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// rice_run_serializer_if: mask-in / run-out valid-ready stream bundle
// Rev 1.0
// ------------------------------------------------------------------
interface rice_run_serializer_if #(
  parameter int W  = 8,
  parameter int QW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mask;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_run;
  logic          out_last;
  logic          out_sat;

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_run, out_last, out_sat
  );

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_run, out_last, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/rice_run_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// rice_run_serializer: terminator mask -> one Rice quotient per set bit
// Rev 1.0
// ------------------------------------------------------------------
module rice_run_serializer #(
  parameter int W  = 8,
  parameter int N  = 2,
  parameter int QW = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush,
  rice_run_serializer_if.slave  s,
  output logic                  err
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [QW-1:0] RUN_MAX = '1;
  localparam logic [QW:0]   W_EXT   = (QW+1)'(W);
  localparam logic [QW:0]   W_M1    = (QW+1)'(W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  mask, mask_n;
  logic [PW-1:0] prev_p, prev_p_n;
  logic          first, first_n;
  logic [QW-1:0] carry, carry_n;
  logic          err_n;
  logic [IW-1:0] run_idx, run_idx_n;

  logic [PW-1:0] p;
  logic [W-1:0]  p_onehot;
  logic          is_last;
  logic [QW:0]   p_ext, prev_ext, first_sum, later_sum, run_wide;
  logic          run_sat;
  logic          emitting, hs, accept;
  logic [QW-1:0] carry_base;
  logic [QW:0]   zsum;

  // Highest remaining terminator is the next one in bitstream order
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (mask[i]) p = PW'(i);
    end
    p_onehot = W'(1) << p;
    is_last  = (mask & ~p_onehot) == '0;
  end

  assign p_ext     = (QW+1)'(p);
  assign prev_ext  = (QW+1)'(prev_p);
  assign first_sum = {1'b0, carry} + W_M1 - p_ext;
  assign later_sum = prev_ext - p_ext - (QW+1)'(1);
  assign run_wide  = first ? first_sum : later_sum;
  assign run_sat   = run_wide >= {1'b0, RUN_MAX};

  assign emitting    = (state == EMIT);
  assign s.out_valid = emitting;
  assign s.out_run   = emitting ? (run_sat ? RUN_MAX : run_wide[QW-1:0]) : '0;
  assign s.out_last  = emitting & is_last;
  assign s.out_sat   = emitting & run_sat;
  assign s.in_ready  = !flush && (!emitting || (is_last && s.out_ready));

  assign hs     = emitting && s.out_ready;
  assign accept = s.in_valid && s.in_ready;

  always_comb begin
    state_n    = state;
    mask_n     = mask;
    prev_p_n   = prev_p;
    first_n    = first;
    carry_n    = carry;
    err_n      = err;
    run_idx_n  = run_idx;
    carry_base = carry;
    zsum       = '0;
    if (flush) begin
      state_n   = IDLE;
      mask_n    = '0;
      prev_p_n  = '0;
      first_n   = 1'b0;
      carry_n   = '0;
      err_n     = 1'b0;
      run_idx_n = '0;
    end else begin
      if (s.out_valid && run_sat) err_n = 1'b1;
      if (hs) begin
        mask_n    = mask & ~p_onehot;
        prev_p_n  = p;
        first_n   = 1'b0;
        run_idx_n = run_idx + IW'(1);
        if (first) carry_n = '0;
        if (is_last) begin
          // Zeros below the last terminator open the next word's first run
          carry_n    = QW'(p);
          carry_base = QW'(p);
          state_n    = IDLE;
          run_idx_n  = '0;
        end
      end
      if (accept) begin
        if (s.in_mask == '0) begin
          zsum    = {1'b0, carry_base} + W_EXT;
          carry_n = zsum[QW] ? RUN_MAX : zsum[QW-1:0];
        end else begin
          mask_n    = s.in_mask;
          prev_p_n  = '0;
          first_n   = 1'b1;
          run_idx_n = '0;
          state_n   = EMIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mask    <= '0;
      prev_p  <= '0;
      first   <= 1'b0;
      carry   <= '0;
      err     <= 1'b0;
      run_idx <= '0;
    end else begin
      state   <= state_n;
      mask    <= mask_n;
      prev_p  <= prev_p_n;
      first   <= first_n;
      carry   <= carry_n;
      err     <= err_n;
      run_idx <= run_idx_n;
    end
  end

  a_mask_ones: assert property (@(posedge clk) disable iff (!rst_n)
    (s.in_valid && s.in_ready) |-> ($countones(s.in_mask) <= N));

  a_run_index: assert property (@(posedge clk) disable iff (!rst_n)
    (hs && !flush) |-> (int'(run_idx) < N));

endmodule
`default_nettype wire

// File: doc/rice_run_serializer.md
Name: rice_run_serializer

Overview:
Decode-path stage directly downstream of find_first_n_ones. It accepts a W-bit terminator mask, in which set bits mark unary-code terminators scanned MSB-first, and emits one zero-run length (Rice quotient) per set bit over a valid/ready stream. Zeros after the last terminator of a word carry into the first run of the next word, so quotients may span word boundaries.

Parameters:
W, 8, mask width in bits; matches the upstream find_first_n_ones W.
N, 2, maximum set bits per mask; sizes the internal run index; a mask with more than N ones is a protocol violation (simulation assertion).
QW, 16, width of the run-length output and of the carry accumulator.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort: drops the word in flight and clears the carry
in_valid  in  1  mask valid
in_ready  out  1  mask accepted when in_valid && in_ready
in_mask  in  W  terminator mask; bit W-1 is the first bitstream bit; clear bits are zeros
out_valid  out  1  run valid
out_ready  in  1  downstream accepts run
out_run  out  QW  zero-run length preceding the terminator
out_last  out  1  current run is the last terminator of its word
out_sat  out  1  current run saturated at 2^QW-1
err  out  1  sticky: any saturation since reset or flush

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; carry=0.
  - out_valid=0, out_run=0, out_last=0, out_sat=0, err=0.
  - Working mask and previous position are cleared.
- States: IDLE, EMIT.
- in_ready = (state==IDLE) || (state==EMIT && out_last && out_ready), and is forced to 0 when flush=1.
- Accept with in_mask==0:
  - carry = sat(carry + W).
  - State stays IDLE and no output is produced.
- Accept with in_mask!=0:
  - Load the working mask.
  - Next cycle: state=EMIT, out_valid=1.
  - Latency from accept to first out_valid is 1 cycle.
- Run arithmetic (p = index of the highest set bit remaining in the working mask):
  - First run of a word: carry + (W-1-p).
  - Later runs: prev_p - p - 1.
  - All sums saturate at 2^QW-1. A saturating run sets out_sat=1 and sets err.
- out_last=1 when the current bit is the lowest set bit of the working mask.
- out_valid && !out_ready:
  - out_run, out_last and out_sat hold stable.
  - No state change.
- Handshake on a non-last run: clear bit p and present the next run in the next cycle (one run per cycle).
- Handshake on the last run:
  - carry = p_last, which is the zero count below the lowest terminator.
  - If a new mask is accepted in the same cycle, go back-to-back into EMIT with no bubble. Otherwise go to IDLE with out_valid=0.
- Carry rules:
  - Carry is consumed (reset to 0 before the residual is added) when the first run of a word is emitted.
  - Carry persists across any number of all-zero words, saturating.
- flush=1:
  - Next cycle: IDLE, carry=0, err=0, out_valid=0.
  - flush has priority over every simultaneous handshake.
- Reset mid-EMIT: outputs return to reset values immediately and the in-flight word is lost.
- out_run for a terminator at bit W-1 with carry 0 is 0.

Test Plan:
1. W=8, carry 0, in_mask=8'b0010_0100, out_ready=1 -> runs 2 then 2, out_last 0 then 1; carry becomes 2; next in_mask=8'b1000_0000 -> run 2, out_last=1.
2. Carry 2 from scenario 1, in_mask=8'b0000_0000 then 8'b0001_0000 -> no output for the zero word; then run 13 (2+8+3).
3. Back-to-back: in_mask=8'b1000_0001 followed immediately by 8'b0100_0000, out_ready=1 -> runs 0, 6, 1 on consecutive cycles; in_ready=1 on the last-run cycle; no bubble.
4. Backpressure: in_mask=8'b0001_0010, out_ready low for 3 cycles -> out_run=3 is held stable with out_valid=1 and in_ready=0; after release, run 2 is emitted.
5. QW=4: three zero words then in_mask=8'b1000_0000 -> out_run=15, out_sat=1, err=1; err stays set until flush and clears the cycle after flush.
6. Reset and flush: assert rst_n=0 mid-EMIT -> out_valid=0 immediately; after release, in_mask=8'b1000_0000 gives run 0 (carry cleared). Separately, flush with in_valid=1 -> word not accepted (in_ready=0), carry=0.
